// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports and a per-register pending (scoreboard) bit.
// Optional macro REG_FILE_SB_BYPASS_EN selects write-first forwarding on the read ports.
module reg_file_sb #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wen,
   input  logic [AW-1:0] w_addr,
   input  logic [DW-1:0] dataIn,
   input  logic [AW-1:0] r_addr1,
   input  logic [AW-1:0] r_addr2,
   output logic [DW-1:0] dataOut1,
   output logic [DW-1:0] dataOut2,
   input  logic          rsv_en,
   input  logic [AW-1:0] rsv_addr,
   output logic          busy1,
   output logic          busy2,
   output logic [AW:0]   pend_cnt,
   output logic          all_busy
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE   = (AW+1)'(1);

   logic [DW-1:0]    regs [DEPTH];
   logic [DEPTH-1:0] pending;
   logic [AW:0]      cnt_nxt;
   logic             inc;
   logic             dec;

   // A same-address write and reservation leaves the bit set, so it counts as neither.
   always_comb begin
      inc     = rsv_en && !pending[rsv_addr];
      dec     = wen && pending[w_addr] && !(rsv_en && (rsv_addr == w_addr));
      cnt_nxt = pend_cnt;
      if (inc && !dec)
         cnt_nxt = pend_cnt + ONE;
      else if (dec && !inc)
         cnt_nxt = pend_cnt - ONE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         pending  <= '0;
         pend_cnt <= '0;
         all_busy <= 1'b0;
      end else begin
         if (wen) begin
            regs[w_addr]    <= dataIn;
            pending[w_addr] <= 1'b0;
         end
         // Placed after the write clear so a coinciding reservation wins.
         if (rsv_en)
            pending[rsv_addr] <= 1'b1;
         pend_cnt <= cnt_nxt;
         all_busy <= (cnt_nxt == FULL);
      end
   end

`ifdef REG_FILE_SB_BYPASS_EN
   logic fwd_busy;

   always_comb begin
      fwd_busy = rsv_en && (rsv_addr == w_addr);
      dataOut1 = regs[r_addr1];
      busy1    = pending[r_addr1];
      dataOut2 = regs[r_addr2];
      busy2    = pending[r_addr2];
      if (wen && (w_addr == r_addr1)) begin
         dataOut1 = dataIn;
         busy1    = fwd_busy;
      end
      if (wen && (w_addr == r_addr2)) begin
         dataOut2 = dataIn;
         busy2    = fwd_busy;
      end
   end
`else
   always_comb begin
      dataOut1 = regs[r_addr1];
      busy1    = pending[r_addr1];
      dataOut2 = regs[r_addr2];
      busy2    = pending[r_addr2];
   end
`endif

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DW, default 8, data width in bits (1..32).
REQ-002 The block SHALL have parameter AW, default 2, address width; depth = 2**AW registers (AW 1..5).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Ports SHALL be, one per line:
  clk       in   1       clock, all state on rising edge
  rst_n     in   1       synchronous active-low reset
  wen       in   1       write enable
  w_addr    in   AW      write address
  dataIn    in   DW      write data
  r_addr1   in   AW      read address, port 1
  r_addr2   in   AW      read address, port 2
  dataOut1  out  DW      read data, port 1
  dataOut2  out  DW      read data, port 2
  rsv_en    in   1       reserve register (mark write pending)
  rsv_addr  in   AW      register to reserve
  busy1     out  1       register at r_addr1 has a pending write
  busy2     out  1       register at r_addr2 has a pending write
  pend_cnt  out  AW+1    number of registers currently pending
  all_busy  out  1       every register pending

Function
REQ-005 Storage SHALL be 2**AW registers of DW bits plus one pending bit per register.
REQ-006 On a rising edge with wen=1, register[w_addr] SHALL take dataIn and pending[w_addr] SHALL clear.
REQ-007 On a rising edge with rsv_en=1, pending[rsv_addr] SHALL set.
REQ-008 rsv_en and wen to the same address in one cycle: data written AND pending SHALL remain/become set (reservation wins; new producer).
REQ-009 rsv_en on an already-pending register SHALL leave it pending; no count change, no error.
REQ-010 wen to a non-pending register SHALL write normally; pending stays 0.
REQ-011 dataOutN SHALL be combinational from register[r_addrN] (0 cycles latency), subject to REQ-018.
REQ-012 busyN SHALL be combinational: pending[r_addrN], subject to REQ-018.
REQ-013 pend_cnt SHALL be a registered counter equal to popcount(pending) after every edge; +1 on set of a clear bit, -1 on clear of a set bit, unchanged when a set and a clear (different addresses) coincide.
REQ-014 pend_cnt SHALL never exceed 2**AW or underflow; all_busy SHALL equal (pend_cnt == 2**AW), registered.
REQ-015 Both read ports SHALL operate independently; r_addr1 == r_addr2 SHALL return identical data/busy.

Reset
REQ-016 rst_n=0 at a rising edge SHALL clear all registers to 0, all pending bits, pend_cnt=0, all_busy=0; wen and rsv_en SHALL be ignored that cycle.
REQ-017 Reset asserted mid-operation SHALL discard any in-flight write/reservation; first post-reset edge behaves as from power-on.

Configuration
REQ-018 Macro REG_FILE_SB_BYPASS_EN: when defined, if wen=1 and w_addr==r_addrN then dataOutN SHALL equal dataIn and busyN SHALL equal (rsv_en && rsv_addr==w_addr) in the same cycle (write-first forwarding); when undefined, dataOutN/busyN SHALL show pre-write register and pending state (read-first).

Verification
REQ-019 Reset then read all addresses -> dataOut1/2 = 0, busy1/2 = 0, pend_cnt = 0, all_busy = 0.
REQ-020 rsv_en addr 2; next cycle r_addr1=2 -> busy1=1, pend_cnt=1; wen addr 2 data 0xA5 -> next cycle dataOut1=0xA5, busy1=0, pend_cnt=0.
REQ-021 Same cycle wen addr1 data 0x3C, rsv_en addr1 -> next cycle register1=0x3C, busy=1, pend_cnt=1.
REQ-022 Reserve addresses 0..3 over 4 cycles (AW=2) -> pend_cnt=4, all_busy=1; then wen addr0 together with rsv_en addr0 -> pend_cnt stays 4.
REQ-023 Register 3 holds 0x11, wen addr3 data 0x77, r_addr2=3 same cycle -> dataOut2=0x77 with REG_FILE_SB_BYPASS_EN, 0x11 without.
REQ-024 rsv_en addr1, then rst_n=0 with wen addr1 data 0xFF -> after reset register1=0, busy=0, pend_cnt=0.
